// File: rtl/stopwatch_display_scan.sv
// Four-digit multiplexed seven-segment driver for an MM:SS stopwatch.
// Scans digit0..digit3 under control of a one-cycle tick_scan pulse, inserts a
// blank cycle on every advance to suppress ghosting, and supports a lap freeze
// that holds a snapshot of the digits while the live counters keep running.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks a zero minutes-tens digit.
module stopwatch_display_scan (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_scan,
  input  logic       lap,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       frozen
);

  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegDash  = 7'b0111111;
  localparam logic [3:0] AnOff    = 4'b1111;

  // Segment pattern {g,f,e,d,c,b,a}, active-low; non-BCD codes show a dash.
  function automatic logic [6:0] decode(input logic [3:0] val);
    logic [6:0] s;
    unique case (val)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SegDash;
    endcase
    return s;
  endfunction

  // Active-low one-hot anode enable for scan position idx.
  function automatic logic [3:0] onehot_low(input logic [1:0] idx);
    logic [3:0] a;
    unique case (idx)
      2'd0:    a = 4'b1110;
      2'd1:    a = 4'b1101;
      2'd2:    a = 4'b1011;
      default: a = 4'b0111;
    endcase
    return a;
  endfunction

  logic [1:0]  sel_q, sel_d;
  logic        blank_q, blank_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic        dp_q, dp_d;
  logic        lap_q, lap_d;
  logic        frozen_q, frozen_d;
  logic [15:0] snap_q, snap_d;

  logic        lap_rise;
  logic [15:0] live_digits;
  logic [15:0] src;
  logic [3:0]  src_digit;
  logic [6:0]  digit_seg;

  assign live_digits = {digit3, digit2, digit1, digit0};
  assign lap_rise    = lap & ~lap_q;

  // Display source: frozen snapshot or live counters.
  assign src = frozen_q ? snap_q : live_digits;

  // Pick the nibble under the scan pointer.
  always_comb begin
    src_digit = src[3:0];
    unique case (sel_q)
      2'd0:    src_digit = src[3:0];
      2'd1:    src_digit = src[7:4];
      2'd2:    src_digit = src[11:8];
      default: src_digit = src[15:12];
    endcase
  end

  // Segment pattern for the selected digit, with optional leading-zero blanking.
  always_comb begin
    digit_seg = decode(src_digit);
`ifdef LEADING_ZERO_BLANK_EN
    if ((sel_q == 2'd3) && (src_digit == 4'd0)) begin
      digit_seg = SegBlank;
    end
`else
    digit_seg = decode(src_digit);
`endif
  end

  // Scan pointer and display outputs: blank on an advance, otherwise show sel.
  always_comb begin
    sel_d   = sel_q;
    blank_d = 1'b0;
    an_d    = onehot_low(sel_q);
    seg_d   = digit_seg;
    // Decimal point sits between minutes and seconds, i.e. lit with digit2.
    dp_d    = (sel_q == 2'd2) ? 1'b0 : 1'b1;
    if (tick_scan) begin
      sel_d   = sel_q + 2'd1;
      blank_d = 1'b1;
      an_d    = AnOff;
      seg_d   = SegBlank;
      dp_d    = 1'b1;
    end
  end

  // Lap button: edge detect toggles freeze; snapshot taken on entry to freeze.
  always_comb begin
    lap_d    = lap;
    frozen_d = frozen_q;
    snap_d   = snap_q;
    if (lap_rise) begin
      frozen_d = ~frozen_q;
      if (!frozen_q) begin
        snap_d = live_digits;
      end
    end
  end

  // State update; synchronous reset overrides scan and lap activity.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q    <= 2'd0;
      blank_q  <= 1'b0;
      an_q     <= AnOff;
      seg_q    <= SegBlank;
      dp_q     <= 1'b1;
      lap_q    <= 1'b0;
      frozen_q <= 1'b0;
      snap_q   <= 16'h0000;
    end else begin
      sel_q    <= sel_d;
      blank_q  <= blank_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      lap_q    <= lap_d;
      frozen_q <= frozen_d;
      snap_q   <= snap_d;
    end
  end

  assign seg    = seg_q;
  assign an     = an_q;
  assign dp     = dp_q;
  assign frozen = frozen_q;

  // blank_q marks the ghosting-guard cycle; it is internal status only.
  logic unused_blank;
  assign unused_blank = blank_q;

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Directed bench for stopwatch_display_scan; build with the same
// LEADING_ZERO_BLANK_EN setting as the design.
module tb_stopwatch_display_scan;

  logic       clk;
  logic       reset;
  logic       tick_scan;
  logic       lap;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       frozen;

  int n_checks = 0;
  int n_errors = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] SegLz = 7'b1111111;
`else
  localparam logic [6:0] SegLz = 7'b1000000;
`endif

  stopwatch_display_scan dut (
    .clk      (clk),
    .reset    (reset),
    .tick_scan(tick_scan),
    .lap      (lap),
    .digit0   (digit0),
    .digit1   (digit1),
    .digit2   (digit2),
    .digit3   (digit3),
    .seg      (seg),
    .an       (an),
    .dp       (dp),
    .frozen   (frozen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge; inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_blank(input string tag);
    check_val({tag, "_an"}, 32'(an), 32'hF);
    check_val({tag, "_seg"}, 32'(seg), 32'h7F);
    check_val({tag, "_dp"}, 32'(dp), 32'h1);
  endtask

  task automatic check_disp(input string tag, input logic [3:0] ea, input logic [6:0] es,
                            input logic ed);
    check_val({tag, "_an"}, 32'(an), 32'(ea));
    check_val({tag, "_seg"}, 32'(seg), 32'(es));
    check_val({tag, "_dp"}, 32'(dp), 32'(ed));
  endtask

  // Single tick: one blank cycle, then the next digit.
  task automatic tick_show(input string tag, input logic [3:0] ea, input logic [6:0] es,
                           input logic ed);
    tick_scan = 1'b1;
    cyc();
    check_blank({tag, "_blank"});
    tick_scan = 1'b0;
    cyc();
    check_disp(tag, ea, es, ed);
  endtask

  task automatic lap_pulse();
    lap = 1'b1;
    cyc();
    lap = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick_scan = 1'b0; lap = 1'b0;
    digit0 = 4'd3; digit1 = 4'd5; digit2 = 4'd2; digit3 = 4'd1;
    @(negedge clk);
    repeat (2) cyc();
    check_blank("reset");
    check_val("reset_frozen", 32'(frozen), 32'h0);

    // Scan 3,5,2,1 with ticks every 8 clocks.
    reset = 1'b0;
    cyc();
    check_disp("first_d0", 4'b1110, 7'b0110000, 1'b1);
    repeat (6) cyc();
    tick_show("scan_d1", 4'b1101, 7'b0010010, 1'b1);
    repeat (6) cyc();
    tick_show("scan_d2", 4'b1011, 7'b0100100, 1'b0);
    repeat (6) cyc();
    tick_show("scan_d3", 4'b0111, 7'b1111001, 1'b1);
    repeat (6) cyc();
    tick_show("scan_wrap", 4'b1110, 7'b0110000, 1'b1);

    // Live digit0 change, one clock latency.
    digit0 = 4'd9;
    cyc();
    check_val("live_9", 32'(seg), 32'h10);
    digit0 = 4'd0;
    cyc();
    check_val("live_0", 32'(seg), 32'h40);

    // Lap freeze with 0,4,1,0 then live digits change to 7,5,2,0.
    digit0 = 4'd0; digit1 = 4'd4; digit2 = 4'd1; digit3 = 4'd0;
    lap_pulse();
    check_val("lap_frozen", 32'(frozen), 32'h1);
    digit0 = 4'd7; digit1 = 4'd5; digit2 = 4'd2; digit3 = 4'd0;
    cyc();
    check_val("frz_d0", 32'(seg), 32'h40);
    tick_show("frz_d1", 4'b1101, 7'b0011001, 1'b1);
    tick_show("frz_d2", 4'b1011, 7'b1111001, 1'b0);
    tick_show("frz_d3", 4'b0111, SegLz, 1'b1);
    tick_show("frz_d0b", 4'b1110, 7'b1000000, 1'b1);
    lap_pulse();
    check_val("unfrz", 32'(frozen), 32'h0);
    cyc();
    check_val("live_d0", 32'(seg), 32'h78);
    tick_show("live_d1", 4'b1101, 7'b0010010, 1'b1);
    tick_show("live_d2", 4'b1011, 7'b0100100, 1'b0);
    tick_show("live_d3", 4'b0111, SegLz, 1'b1);
    tick_show("live_d0b", 4'b1110, 7'b1111000, 1'b1);

    // Lap held 20 clocks toggles only once.
    lap = 1'b1;
    repeat (20) cyc();
    check_val("hold_frozen", 32'(frozen), 32'h1);
    lap = 1'b0;
    cyc();
    check_val("hold_release", 32'(frozen), 32'h1);
    lap_pulse();
    check_val("hold_unfrz", 32'(frozen), 32'h0);

    // Non-BCD digit shows a dash.
    digit1 = 4'd12;
    tick_show("dash", 4'b1101, 7'b0111111, 1'b1);

    // Held tick with a coincident lap edge: sel 1 -> 2 after five advances.
    tick_scan = 1'b1; lap = 1'b1;
    cyc();
    check_blank("held_t1");
    check_val("coinc_frozen", 32'(frozen), 32'h1);
    lap = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check_blank("held_tn");
    end
    digit2 = 4'd9;
    tick_scan = 1'b0;
    cyc();
    check_disp("held_snap_d2", 4'b1011, 7'b0100100, 1'b0);

    // Reset while frozen at sel=2 overrides tick and lap.
    reset = 1'b1; tick_scan = 1'b1; lap = 1'b1;
    cyc();
    check_blank("mid_reset");
    check_val("mid_reset_frozen", 32'(frozen), 32'h0);
    reset = 1'b0; tick_scan = 1'b0; lap = 1'b0;
    cyc();
    check_disp("post_reset", 4'b1110, 7'b1111000, 1'b1);
    check_val("post_reset_frozen", 32'(frozen), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_display_scan.md
STOPWATCH_DISPLAY_SCAN -- requirements
Module: stopwatch_display_scan

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 tick_scan  input  1  one-clk scan-advance pulse.
REQ-005 lap  input  1  lap button level, already debounced.
REQ-006 digit0  input  4  BCD seconds units (mod-10 counter).
REQ-007 digit1  input  4  BCD seconds tens (mod-6 counter).
REQ-008 digit2  input  4  BCD minutes units.
REQ-009 digit3  input  4  BCD minutes tens.
REQ-010 seg  output  7  {g,f,e,d,c,b,a}, active-low, registered.
REQ-011 an  output  4  one-hot-low digit enables, an[i] selects digit i, registered.
REQ-012 dp  output  1  active-low decimal point, registered.
REQ-013 frozen  output  1  high while the lap snapshot is displayed.

Function
REQ-014 The scan pointer sel SHALL take values 0..3 and advance 0->1->2->3->0 on each clk edge with tick_scan=1.
REQ-015 On an edge with tick_scan=1, outputs SHALL be driven blank (an=1111, seg=1111111, dp=1) for exactly the following cycle; this is the ghosting guard.
REQ-016 On every edge with tick_scan=0, an SHALL take onehot_low(sel) and seg SHALL take decode(src[sel]); update latency is one clk after a source change.
REQ-017 dp SHALL be 0 exactly when an=1011 (between minutes and seconds); otherwise it SHALL be 1.
REQ-018 decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; any value 10-15 SHALL give dash 0111111.
REQ-019 lap SHALL be registered into lap_q; a rising edge (lap=1, lap_q=0) SHALL toggle frozen.
REQ-020 On the edge where frozen goes 0->1, digit0..3 SHALL be captured into a 16-bit snapshot in that same edge.
REQ-021 src SHALL be the snapshot while frozen=1, and the live digits otherwise; live inputs continue to change unobserved while frozen.
REQ-022 A lap edge coinciding with tick_scan SHALL be processed independently; both take effect on the same edge.
REQ-023 Holding lap high SHALL toggle frozen once only; a new toggle requires lap to return low for at least one clk.
REQ-024 tick_scan held high for consecutive cycles SHALL advance sel on every edge while outputs stay blank.

Reset
REQ-025 With reset=1 at an edge, the block SHALL set sel=0, an=1111, seg=1111111, dp=1, frozen=0, lap_q=0, snapshot=0, and clear the blank flag.
REQ-026 Reset SHALL override tick_scan and lap in the same cycle.
REQ-027 Reset asserted mid-scan or while frozen SHALL return the block to live display starting at digit 0.
REQ-028 On the first edge after reset deasserts with tick_scan=0, the block SHALL drive an=1110 and seg=decode(digit0).

Configuration
REQ-029 Macro LEADING_ZERO_BLANK_EN, when defined: when sel=3 and src digit3=0, seg SHALL be 1111111 while an=0111 is still driven.
REQ-030 LEADING_ZERO_BLANK_EN undefined: digit3=0 SHALL display 1000000; all other behaviour is identical.

Verification
REQ-031 Reset, then digits 3,5,2,1 (d0..d3), tick_scan every 8 clks -> an sequence 1110,1101,1011,0111, each preceded by one 1111 cycle; seg = 0110000, 0010010, 0100100 with dp=0, then 1111001.
REQ-032 Live digit0 9->0 while sel=0 -> seg goes 0010000->1000000 exactly one clk later.
REQ-033 Pulse lap with digits 0,4,1,0, then change digits to 7,5,2,0 -> frozen=1 and display stays 0,4,1,0; a second lap pulse -> frozen=0 and 7,5,2,0 shown next scan.
REQ-034 lap held high for 20 clks -> frozen toggles once; digit1=12 -> dash 0111111 when sel=1.
REQ-035 Reset pulsed while frozen=1 and sel=2 -> next cycle all outputs at reset values, frozen=0; then an=1110 on the following edge.
REQ-036 digit3=0 at sel=3 -> seg=1111111 with LEADING_ZERO_BLANK_EN defined, seg=1000000 without it; an=0111 in both builds.
